vga_timing_gen: RTL

Parametrised VGA raster timing generator. It replaces the fixed 640x480 horizontal counter, vertical counter and sync logic with one configurable block. It also produces character-cell fetch strobes, the frame counter and the blink phase, and delays the sync and blanking outputs by a configurable pipeline depth so they stay aligned with the downstream VRAM → glyph → pixel path. It sits between the dot clock and the readout and output stages of the text-mode display.

---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_delay_line.sv | 39 +++
 rtl/vga_timing_gen.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and helpers for the raster timing generator.
// Defaults describe 640x480@60 with a 25.175 MHz dot clock.
package vga_pkg;

   localparam int POS_W = 12;

   localparam int H_VIS_DEF  = 640;
   localparam int H_FP_DEF   = 16;
   localparam int H_SYNC_DEF = 96;
   localparam int H_BP_DEF   = 48;
   localparam int V_VIS_DEF  = 480;
   localparam int V_FP_DEF   = 10;
   localparam int V_SYNC_DEF = 2;
   localparam int V_BP_DEF   = 33;

   function automatic int h_total(input int vis, input int fp, input int sync, input int bp);
      return vis + fp + sync + bp;
   endfunction

   function automatic int v_total(input int vis, input int fp, input int sync, input int bp);
      return vis + fp + sync + bp;
   endfunction

   function automatic bit is_pow2(input int n);
      return (n > 0) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Synchronous-reset shift register; every stage reloads RESET_VAL on reset.
module vga_delay_line #(
   parameter int               WIDTH     = 1,
   parameter int               DEPTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_q [DEPTH];
   logic [WIDTH-1:0] stage_d [DEPTH];

   // Next-stage values: input enters stage 0, each stage takes its predecessor
   always_comb begin
      stage_d[0] = din;
      for (int i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   // Stage registers
   always_ff @(posedge clk) begin
      if (!nrst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= RESET_VAL;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
         end
      end
   end

   assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Configurable VGA raster timing: position counters, character-cell decode,
// frame counter/blink and pipeline-aligned sync/blanking outputs.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_VIS      = H_VIS_DEF,
   parameter int H_FP       = H_FP_DEF,
   parameter int H_SYNC     = H_SYNC_DEF,
   parameter int H_BP       = H_BP_DEF,
   parameter int V_VIS      = V_VIS_DEF,
   parameter int V_FP       = V_FP_DEF,
   parameter int V_SYNC     = V_SYNC_DEF,
   parameter int V_BP       = V_BP_DEF,
   parameter bit H_POL      = 1'b0,
   parameter bit V_POL      = 1'b0,
   parameter int CHAR_W     = 8,
   parameter int CHAR_H     = 16,
   parameter int PIPE_DELAY = 3,
   parameter int FRAME_W    = 10,
   parameter int BLINK_BIT  = 5
) (
   input  logic               clk,
   input  logic               nrst,
   output logic [POS_W-1:0]   hPos,
   output logic [POS_W-1:0]   vPos,
   output logic               charStrobe,
   output logic [7:0]         charCol,
   output logic [7:0]         charRow,
   output logic [4:0]         glyphRow,
   output logic               lineEnd,
   output logic               frameStart,
   output logic               hSync,
   output logic               vSync,
   output logic               nVis,
   output logic [FRAME_W-1:0] frameCount,
   output logic               blink
);

   if (!is_pow2(CHAR_W)) begin : g_err_char_w
      $error("CHAR_W must be a power of two");
   end
   if (!is_pow2(CHAR_H) || CHAR_H > 32) begin : g_err_char_h
      $error("CHAR_H must be a power of two no larger than 32");
   end
   if (PIPE_DELAY < 1) begin : g_err_pipe
      $error("PIPE_DELAY must be at least 1");
   end
   if ((H_VIS % CHAR_W) != 0) begin : g_err_hvis
      $error("H_VIS must be divisible by CHAR_W");
   end
   if (BLINK_BIT >= FRAME_W) begin : g_err_blink
      $error("BLINK_BIT must index into frameCount");
   end

   localparam logic [POS_W-1:0] H_LAST     = POS_W'(h_total(H_VIS, H_FP, H_SYNC, H_BP) - 1);
   localparam logic [POS_W-1:0] V_LAST     = POS_W'(v_total(V_VIS, V_FP, V_SYNC, V_BP) - 1);
   localparam logic [POS_W-1:0] H_VIS_P    = POS_W'(H_VIS);
   localparam logic [POS_W-1:0] V_VIS_P    = POS_W'(V_VIS);
   localparam logic [POS_W-1:0] H_SYNC_LO  = POS_W'(H_VIS + H_FP);
   localparam logic [POS_W-1:0] H_SYNC_HI  = POS_W'(H_VIS + H_FP + H_SYNC);
   localparam logic [POS_W-1:0] V_SYNC_LO  = POS_W'(V_VIS + V_FP);
   localparam logic [POS_W-1:0] V_SYNC_HI  = POS_W'(V_VIS + V_FP + V_SYNC);
   localparam logic [POS_W-1:0] CW_MASK    = POS_W'(CHAR_W - 1);
   localparam logic [4:0]       GLYPH_LAST = 5'(CHAR_H - 1);

   logic [POS_W-1:0]   h_pos_q, h_pos_d, v_pos_q, v_pos_d;
   logic [7:0]         char_col_q, char_col_d, char_row_q, char_row_d;
   logic [4:0]         glyph_row_q, glyph_row_d;
   logic [FRAME_W-1:0] frame_count_q, frame_count_d;
   logic               h_wrap_s, v_wrap_s, cell_end_s, glyph_wrap_s, visible_s;
   logic [2:0]         raw_s, dly_s;

   // Counter next-state; character counters step alongside the position counters
   always_comb begin
      h_wrap_s     = (h_pos_q == H_LAST);
      v_wrap_s     = (v_pos_q == V_LAST);
      cell_end_s   = ((h_pos_q & CW_MASK) == CW_MASK);
      glyph_wrap_s = (glyph_row_q == GLYPH_LAST);
      v_pos_d       = v_pos_q;
      char_row_d    = char_row_q;
      glyph_row_d   = glyph_row_q;
      frame_count_d = frame_count_q;
      if (h_wrap_s) begin
         h_pos_d    = {POS_W{1'b0}};
         char_col_d = 8'd0;
         if (v_wrap_s) begin
            v_pos_d       = {POS_W{1'b0}};
            glyph_row_d   = 5'd0;
            char_row_d    = 8'd0;
            frame_count_d = frame_count_q + FRAME_W'(1);
         end else if (glyph_wrap_s) begin
            v_pos_d     = v_pos_q + POS_W'(1);
            glyph_row_d = 5'd0;
            char_row_d  = char_row_q + 8'd1;
         end else begin
            v_pos_d     = v_pos_q + POS_W'(1);
            glyph_row_d = glyph_row_q + 5'd1;
         end
      end else if (cell_end_s) begin
         h_pos_d    = h_pos_q + POS_W'(1);
         char_col_d = char_col_q + 8'd1;
      end else begin
         h_pos_d    = h_pos_q + POS_W'(1);
         char_col_d = char_col_q;
      end
   end

   // Counter registers
   always_ff @(posedge clk) begin
      if (!nrst) begin
         h_pos_q       <= {POS_W{1'b0}};
         v_pos_q       <= {POS_W{1'b0}};
         char_col_q    <= 8'd0;
         char_row_q    <= 8'd0;
         glyph_row_q   <= 5'd0;
         frame_count_q <= {FRAME_W{1'b0}};
      end else begin
         h_pos_q       <= h_pos_d;
         v_pos_q       <= v_pos_d;
         char_col_q    <= char_col_d;
         char_row_q    <= char_row_d;
         glyph_row_q   <= glyph_row_d;
         frame_count_q <= frame_count_d;
      end
   end

   // Undelayed sync/blanking decode of the current position
   always_comb begin
      visible_s = (h_pos_q < H_VIS_P) && (v_pos_q < V_VIS_P);
      raw_s[2]  = (h_pos_q >= H_SYNC_LO) && (h_pos_q < H_SYNC_HI);
      raw_s[1]  = (v_pos_q >= V_SYNC_LO) && (v_pos_q < V_SYNC_HI);
      raw_s[0]  = !visible_s;
   end

   // Reset value: both syncs inactive, blanking asserted
   vga_delay_line #(
      .WIDTH     (3),
      .DEPTH     (PIPE_DELAY),
      .RESET_VAL (3'b001)
   ) u_sync_dly (
      .clk  (clk),
      .nrst (nrst),
      .din  (raw_s),
      .dout (dly_s)
   );

   assign hPos       = h_pos_q;
   assign vPos       = v_pos_q;
   assign charCol    = char_col_q;
   assign charRow    = char_row_q;
   assign glyphRow   = glyph_row_q;
   assign charStrobe = nrst && visible_s && ((h_pos_q & CW_MASK) == {POS_W{1'b0}});
   assign lineEnd    = nrst && h_wrap_s;
   assign frameStart = nrst && (h_pos_q == {POS_W{1'b0}}) && (v_pos_q == {POS_W{1'b0}});
   assign hSync      = H_POL ? dly_s[2] : !dly_s[2];
   assign vSync      = V_POL ? dly_s[1] : !dly_s[1];
   assign nVis       = dly_s[0];
   assign frameCount = frame_count_q;
   assign blink      = frame_count_q[BLINK_BIT];

endmodule
